// File: rtl/updi_uart_rx_if.sv
// Receive-side result bus of the UPDI UART receiver.
// valid is a one-cycle pulse with no backpressure: data/parity_err/frame_err are meaningful only while valid=1.
interface updi_uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       busy;
    logic [2:0] state_dbg;

    modport master (
        output data, valid, parity_err, frame_err, break_det, busy, state_dbg
    );
    modport slave (
        input data, valid, parity_err, frame_err, break_det, busy, state_dbg
    );
endinterface

// File: rtl/updi_uart_rx.sv
// UPDI UART receiver: start, 8 data LSB first, even parity, 2 stops; detects BREAK.
// Results are committed one cycle after the stop2 sample.
module updi_uart_rx #(
    parameter int unsigned DIV = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    updi_uart_rx_if.master bus
);
    localparam int unsigned   CW      = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] RELOAD  = CW'(DIV - 1);

    typedef enum logic [2:0] {
        WAIT_HIGH, IDLE, START, DATA, PARITY, STOP1, STOP2
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, rx_s_q, rx_s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d, stop1_q, stop1_d, zero_q, zero_d;
    logic          fin_q, fin_d, brk_pend_q, brk_pend_d;
    logic          pe_pend_q, pe_pend_d, fe_pend_q, fe_pend_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
    logic          tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        sync1_d    = rx;
        rx_s_d     = sync1_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop1_d    = stop1_q;
        zero_d     = zero_q;
        fin_d      = 1'b0;
        brk_pend_d = brk_pend_q;
        pe_pend_d  = pe_pend_q;
        fe_pend_d  = fe_pend_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
        brk_d      = 1'b0;

        // Commit cycle: shift_q is still untouched because a new frame cannot reach DATA yet.
        if (fin_q) begin
            if (brk_pend_q) begin
                brk_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = shift_q;
                pe_d    = pe_pend_q;
                fe_d    = fe_pend_q;
            end
        end

        if (state_q != WAIT_HIGH && state_q != IDLE && !tick) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            WAIT_HIGH: if (rx_s_q) state_d = IDLE;
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = RELOAD;
                        bit_d   = 3'd0;
                        zero_d  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    zero_d  = zero_q & ~rx_s_q;
                    cnt_d   = RELOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (tick) begin
                    par_d   = rx_s_q;
                    zero_d  = zero_q & ~rx_s_q;
                    cnt_d   = RELOAD;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (tick) begin
                    stop1_d = rx_s_q;
                    zero_d  = zero_q & ~rx_s_q;
                    cnt_d   = RELOAD;
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (tick) begin
                    state_d    = WAIT_HIGH;
                    cnt_d      = '0;
                    fin_d      = 1'b1;
                    brk_pend_d = zero_q & ~rx_s_q;
                    pe_pend_d  = par_q ^ (^shift_q);
                    fe_pend_d  = ~stop1_q | ~rx_s_q;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_HIGH;
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            stop1_q    <= 1'b0;
            zero_q     <= 1'b0;
            fin_q      <= 1'b0;
            brk_pend_q <= 1'b0;
            pe_pend_q  <= 1'b0;
            fe_pend_q  <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rx_s_q     <= rx_s_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop1_q    <= stop1_d;
            zero_q     <= zero_d;
            fin_q      <= fin_d;
            brk_pend_q <= brk_pend_d;
            pe_pend_q  <= pe_pend_d;
            fe_pend_q  <= fe_pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;
    assign bus.break_det  = brk_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_updi_uart_rx.sv
// Directed bench for updi_uart_rx at DIV=4: good frame, parity error, frame error,
// BREAK, glitch and mid-frame reset, with a monitor-fed scoreboard.
module tb_updi_uart_rx;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    int   cyc = 0;

    updi_uart_rx_if bus ();

    updi_uart_rx #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_brk   = 0;
    int viol    = 0;
    int last_valid_cyc = 0;
    int frame_c = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples 1 ns after each rising edge, scores frames against exp_q {fe, pe, data}.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {22'd0, bus.frame_err, bus.parity_err, bus.data}, 32'h3ff);
                end else begin
                    check("frame", {22'd0, bus.frame_err, bus.parity_err, bus.data},
                          {22'd0, exp_q.pop_front()});
                end
            end
            if (bus.break_det) n_brk++;
            if (bus.valid && bus.break_det) viol++;
            if (!bus.valid && (bus.parity_err || bus.frame_err)) viol++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        logic [11:0] bits;
        bits = {s2, s1, par, d, 1'b0};
        frame_c = cyc;
        for (int i = 0; i < 12; i++) begin
            rx = bits[i];
            wait_cycles(DIV);
        end
    endtask

    int nv0, nb0;

    initial begin
        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(3);
        check("rst_data", {24'd0, bus.data}, 32'h00);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_perr", {31'd0, bus.parity_err}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("rst_brk", {31'd0, bus.break_det}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        wait_cycles(3);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // 0x55, good parity and stops; detect at frame_c+3, valid at T0+47
        nv0 = n_valid;
        exp_q.push_back({1'b0, 1'b0, 8'h55});
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        wait_cycles(6);
        check("cnt_55", n_valid - nv0, 32'd1);
        check("lat_55", last_valid_cyc - frame_c, 32'd50);

        // 0x07 with wrong parity bit
        nv0 = n_valid;
        exp_q.push_back({1'b0, 1'b1, 8'h07});
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        wait_cycles(6);
        check("cnt_07", n_valid - nv0, 32'd1);

        // 0xA3 with stop2 low; line stays low afterwards
        nv0 = n_valid;
        exp_q.push_back({1'b1, 1'b0, 8'hA3});
        send_frame(8'hA3, 1'b0, 1'b1, 1'b0);
        wait_cycles(8);
        check("cnt_a3", n_valid - nv0, 32'd1);
        check("a3_busy_low", {31'd0, bus.busy}, 32'd1);
        rx = 1'b1;
        wait_cycles(2);
        check("a3_busy_rise2", {31'd0, bus.busy}, 32'd1);
        wait_cycles(1);
        check("a3_idle_rise3", {31'd0, bus.busy}, 32'd0);
        wait_cycles(4);

        // BREAK: 20 bit times low
        nv0 = n_valid;
        nb0 = n_brk;
        rx = 1'b0;
        wait_cycles(20 * DIV);
        check("brk_busy_low", {31'd0, bus.busy}, 32'd1);
        rx = 1'b1;
        wait_cycles(2);
        check("brk_busy_rise2", {31'd0, bus.busy}, 32'd1);
        wait_cycles(1);
        check("brk_idle_rise3", {31'd0, bus.busy}, 32'd0);
        check("brk_count", n_brk - nb0, 32'd1);
        check("brk_no_valid", n_valid - nv0, 32'd0);
        check("brk_data_held", {24'd0, bus.data}, 32'hA3);
        wait_cycles(4);

        // One-cycle glitch: T0 three edges later, false start at T0+H
        nv0 = n_valid;
        nb0 = n_brk;
        rx = 1'b0;
        wait_cycles(1);
        rx = 1'b1;
        wait_cycles(2);
        check("glitch_busy_t0", {31'd0, bus.busy}, 32'd1);
        wait_cycles(2);
        check("glitch_idle", {31'd0, bus.busy}, 32'd0);
        wait_cycles(60);
        check("glitch_no_valid", n_valid - nv0, 32'd0);
        check("glitch_no_brk", n_brk - nb0, 32'd0);

        // Reset in the middle of data bit 4, then a clean 0x3C
        nv0 = n_valid;
        nb0 = n_brk;
        rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            wait_cycles(DIV);
        end
        rx = 1'b0;
        wait_cycles(2);
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(60);
        check("abort_no_valid", n_valid - nv0, 32'd0);
        check("abort_no_brk", n_brk - nb0, 32'd0);
        check("abort_idle", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back({1'b0, 1'b0, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        wait_cycles(6);
        check("cnt_3c", n_valid - nv0, 32'd1);
        check("data_3c", {24'd0, bus.data}, 32'h3C);

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("qualifiers", viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/updi_uart_rx.md
UPDI_UART_RX -- requirements
Module: updi_uart_rx

Interface
REQ-001 SHALL have parameter DIV, default 16, clock cycles per UPDI bit; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 SHALL have port rx, input, 1 bit, asynchronous UPDI line; idle high.
REQ-005 SHALL have port data, output, 8 bits, last received data byte.
REQ-006 SHALL have port valid, output, 1 bit, one-cycle pulse when a frame completes.
REQ-007 SHALL have port parity_err, output, 1 bit, qualified by valid; even-parity mismatch.
REQ-008 SHALL have port frame_err, output, 1 bit, qualified by valid; a stop bit was sampled low.
REQ-009 SHALL have port break_det, output, 1 bit, one-cycle pulse on BREAK detection.
REQ-010 SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (rx_s) before any use; the synchronizer resets to 1.
REQ-012 SHALL receive the UPDI frame: start bit (0), 8 data bits LSB first, even parity bit, and 2 stop bits (1).
REQ-013 SHALL implement states WAIT_HIGH, IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-014 SHALL, in WAIT_HIGH, move to IDLE in the cycle after rx_s = 1.
REQ-015 SHALL, in IDLE, move to START when rx_s = 0; call that detection cycle T0.
REQ-016 SHALL sample the start bit at T0+H, where H = DIV/2 (floor).
REQ-017 SHALL sample bit k (k = 1..8 data, 9 parity, 10 stop1, 11 stop2) at T0+H+k*DIV.
REQ-018 SHALL treat a start sample of 1 as a false start: return to IDLE with no output pulse.
REQ-019 SHALL use a bit-period counter of width clog2(DIV) that reloads at every sample point and never wraps mid-bit.
REQ-020 SHALL use a data-bit counter of 0..7 that advances DATA to PARITY after the 8th sample.
REQ-021 SHALL set parity_err = (parity sample != XOR of the 8 data bits).
REQ-022 SHALL set frame_err = (stop1 sample == 0) OR (stop2 sample == 0).
REQ-023 SHALL treat a frame whose start, 8 data, parity, stop1 and stop2 samples are all 0 as BREAK.
REQ-024 SHALL, on BREAK, pulse break_det at T0+H+11*DIV+1, keep valid low, and leave data unchanged.
REQ-025 SHALL, on a non-BREAK frame, at T0+H+11*DIV+1:
  - update data;
  - pulse valid for exactly 1 cycle;
  - drive parity_err and frame_err for that same cycle, and hold them at 0 otherwise.
REQ-026 SHALL enter WAIT_HIGH after STOP2 in all cases; a line held low therefore never produces a second frame or BREAK.
REQ-027 SHALL never assert valid and break_det in the same cycle.
REQ-028 SHALL hold data between frames.

Reset
REQ-029 SHALL, while rst = 1 at a clk edge, force:
  - state to WAIT_HIGH;
  - all counters to 0, shift register to 0, synchronizer flops to 1;
  - data = 0, valid = 0, parity_err = 0, frame_err = 0, break_det = 0, busy = 1.
REQ-030 SHALL abandon any frame in progress when rst asserts mid-frame, with no output pulse after rst deasserts.
REQ-031 SHALL require rx_s = 1 after reset before any start bit is accepted.

Verification (DIV = 4, H = 2, bit period = 40 ns at 10 ns clk)
REQ-032 SHALL cover: rx high, 0x55 sent with parity 0 and stops 1,1 -> one valid pulse, data = 0x55, parity_err = 0, frame_err = 0, valid at T0+47.
REQ-033 SHALL cover: 0x07 sent with parity bit 0 (correct parity is 1) -> valid with data = 0x07, parity_err = 1, frame_err = 0.
REQ-034 SHALL cover: 0xA3 sent with correct parity and stop2 = 0 -> valid with data = 0xA3, frame_err = 1; busy stays high until rx returns high.
REQ-035 SHALL cover: rx held low for 20 bit times, then high -> exactly one break_det pulse, no valid, data unchanged; IDLE reached 3 cycles after the rise.
REQ-036 SHALL cover: rx low for 1 cycle only (glitch) -> false start, no pulses, busy back to 0 within H+1 cycles of T0.
REQ-037 SHALL cover: rst asserted at data bit 4 of a frame, then a clean 0x3C frame -> no pulse from the aborted frame, one valid with data = 0x3C.
